alu: RTL and testbench



---
 rtl/alu_pkg.sv | 11 +
 rtl/alu_if.sv | 21 ++
 rtl/alu_adder32.sv | 55 +++++
 rtl/alu.sv | 110 +++++++++++
 tb/tb_alu.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the execute-stage ALU: datapath width and opcode encodings.
package alu_pkg;
  localparam int DATA_W = 32;

  localparam logic [4:0] OP_ADD = 5'b00000;
  localparam logic [4:0] OP_SUB = 5'b00001;
  localparam logic [4:0] OP_AND = 5'b00010;
  localparam logic [4:0] OP_OR  = 5'b00011;
  localparam logic [4:0] OP_SLL = 5'b00100;
  localparam logic [4:0] OP_SRA = 5'b00101;
endpackage

// File: rtl/alu_if.sv
// Operand/result bundle between the execute stage and the ALU.
interface alu_if;
  logic [alu_pkg::DATA_W-1:0] data_operandA;
  logic [alu_pkg::DATA_W-1:0] data_operandB;
  logic [4:0]                 ctrl_ALUopcode;
  logic [4:0]                 ctrl_shiftamt;
  logic [alu_pkg::DATA_W-1:0] data_result;
  logic                       isNotEqual;
  logic                       isLessThan;
  logic                       overflow;

  modport master (
    output data_operandA, data_operandB, ctrl_ALUopcode, ctrl_shiftamt,
    input  data_result, isNotEqual, isLessThan, overflow
  );

  modport slave (
    input  data_operandA, data_operandB, ctrl_ALUopcode, ctrl_shiftamt,
    output data_result, isNotEqual, isLessThan, overflow
  );
endinterface

// File: rtl/alu_adder32.sv
// 32-bit carry-select adder from four 8-bit ripple blocks; exposes the carries
// into and out of the MSB so callers can form signed overflow as c31 ^ c32.
module alu_adder32
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              cin,
  output logic [DATA_W-1:0] sum,
  output logic              c31,
  output logic              c32
);

  // Returns {carry_out, carry_into_bit7, sum[7:0]}.
  function automatic logic [9:0] ripple8(input logic [7:0] x, input logic [7:0] y,
                                         input logic ci);
    logic [7:0] s;
    logic       c;
    logic       cm;
    c  = ci;
    cm = ci;
    s  = '0;
    for (int i = 0; i < 8; i++) begin
      if (i == 7) cm = c;
      s[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    return {c, cm, s};
  endfunction

  always_comb begin
    logic       carry;
    logic [9:0] r0;
    logic [9:0] r1;
    logic [9:0] sel;
    carry = cin;
    sum   = '0;
    c31   = 1'b0;
    c32   = 1'b0;
    r0    = '0;
    r1    = '0;
    sel   = '0;
    // Each block precomputes both carry-in cases; the incoming carry only picks one.
    for (int k = 0; k < 4; k++) begin
      r0  = ripple8(a[8*k +: 8], b[8*k +: 8], 1'b0);
      r1  = ripple8(a[8*k +: 8], b[8*k +: 8], 1'b1);
      sel = carry ? r1 : r0;
      sum[8*k +: 8] = sel[7:0];
      if (k == 3) c31 = sel[8];
      carry = sel[9];
    end
    c32 = carry;
  end

endmodule

// File: rtl/alu.sv
// Execute-stage ALU: add/sub/and/or/sll/sra with A-B comparison flags,
// all outputs registered one clock after the operands are presented.
module alu
  import alu_pkg::*;
(
  input  logic  clock,
  input  logic  reset,
  alu_if.slave  bus
);

  logic signed [DATA_W-1:0] op_a;
  logic signed [DATA_W-1:0] op_b;
  logic        [4:0]        amt;
  logic                     is_sub;
  logic        [DATA_W-1:0] b_main;

  logic [DATA_W-1:0] sum_main;
  logic              c31_main;
  logic              c32_main;
  logic [DATA_W-1:0] diff;
  logic              c31_cmp;
  logic              c32_cmp;
  logic              ovf_sub;

  logic [DATA_W-1:0] sll_1, sll_2, sll_4, sll_8, sll_16;
  logic [DATA_W-1:0] sra_1, sra_2, sra_4, sra_8, sra_16;

  logic [DATA_W-1:0] result_d, result_q;
  logic              neq_d, neq_q;
  logic              lt_d, lt_q;
  logic              ovf_d, ovf_q;

  assign op_a   = bus.data_operandA;
  assign op_b   = bus.data_operandB;
  assign amt    = bus.ctrl_shiftamt;
  assign is_sub = (bus.ctrl_ALUopcode == OP_SUB);
  assign b_main = is_sub ? ~op_b : op_b;

  alu_adder32 u_add_main (
    .a   (op_a),
    .b   (b_main),
    .cin (is_sub),
    .sum (sum_main),
    .c31 (c31_main),
    .c32 (c32_main)
  );

  // Dedicated A-B path so the flags are valid regardless of opcode.
  alu_adder32 u_add_cmp (
    .a   (op_a),
    .b   (~op_b),
    .cin (1'b1),
    .sum (diff),
    .c31 (c31_cmp),
    .c32 (c32_cmp)
  );

  assign ovf_sub = c31_cmp ^ c32_cmp;

  assign sll_1  = amt[0] ? {op_a[30:0], 1'b0}     : op_a;
  assign sll_2  = amt[1] ? {sll_1[29:0], 2'b0}    : sll_1;
  assign sll_4  = amt[2] ? {sll_2[27:0], 4'b0}    : sll_2;
  assign sll_8  = amt[3] ? {sll_4[23:0], 8'b0}    : sll_4;
  assign sll_16 = amt[4] ? {sll_8[15:0], 16'b0}   : sll_8;

  assign sra_1  = amt[0] ? {{1{op_a[31]}},   op_a[31:1]}   : op_a;
  assign sra_2  = amt[1] ? {{2{sra_1[31]}},  sra_1[31:2]}  : sra_1;
  assign sra_4  = amt[2] ? {{4{sra_2[31]}},  sra_2[31:4]}  : sra_2;
  assign sra_8  = amt[3] ? {{8{sra_4[31]}},  sra_4[31:8]}  : sra_4;
  assign sra_16 = amt[4] ? {{16{sra_8[31]}}, sra_8[31:16]} : sra_8;

  always_comb begin
    result_d = '0;
    ovf_d    = 1'b0;
    case (bus.ctrl_ALUopcode)
      OP_ADD, OP_SUB: begin
        result_d = sum_main;
        ovf_d    = c31_main ^ c32_main;
      end
      OP_AND:  result_d = op_a & op_b;
      OP_OR:   result_d = op_a | op_b;
      OP_SLL:  result_d = sll_16;
      OP_SRA:  result_d = sra_16;
      default: result_d = '0;
    endcase
    neq_d = |diff;
    lt_d  = diff[31] ^ ovf_sub;
  end

  // Output register stage
  always_ff @(posedge clock) begin
    if (reset) begin
      result_q <= '0;
      neq_q    <= 1'b0;
      lt_q     <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      result_q <= result_d;
      neq_q    <= neq_d;
      lt_q     <= lt_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.data_result = result_q;
  assign bus.isNotEqual  = neq_q;
  assign bus.isLessThan  = lt_q;
  assign bus.overflow    = ovf_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: table vectors plus loops, expected results queued
// at drive time and popped one clock later.
module tb_alu;
  import alu_pkg::*;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  amt;
    logic [31:0] res;
    logic        neq;
    logic        lt;
    logic        ovf;
  } vec_t;

  typedef struct {
    int          id;
    logic [31:0] res;
    logic        neq;
    logic        lt;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   next_id = 0;
  exp_t sb[$];

  alu_if bus();

  alu dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input int id, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s vec%0d got=%h want=%h", name, id, got, want);
    end
  endtask

  task automatic check_front();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty got=0 want=1");
      return;
    end
    e = sb.pop_front();
    cmp("result",     e.id, bus.data_result,        e.res);
    cmp("isNotEqual", e.id, {31'b0, bus.isNotEqual}, {31'b0, e.neq});
    cmp("isLessThan", e.id, {31'b0, bus.isLessThan}, {31'b0, e.lt});
    cmp("overflow",   e.id, {31'b0, bus.overflow},   {31'b0, e.ovf});
  endtask

  // Called at a negedge: drive, queue the expectation, check at the next negedge.
  task automatic apply(input logic r, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] amt,
                       input logic [31:0] res, input logic neq, input logic lt,
                       input logic ovf);
    exp_t e;
    rst                = r;
    bus.ctrl_ALUopcode = op;
    bus.data_operandA  = a;
    bus.data_operandB  = b;
    bus.ctrl_shiftamt  = amt;
    e.id  = next_id;
    e.res = res;
    e.neq = neq;
    e.lt  = lt;
    e.ovf = ovf;
    next_id++;
    sb.push_back(e);
    @(negedge clk);
    check_front();
  endtask

  vec_t vecs[$];

  initial begin
    logic [31:0] va;
    logic [31:0] vb;
    logic [31:0] pats [2];
    logic [4:0]  amts [9];
    vec_t v;

    vecs = '{
      '{OP_ADD, 32'h0,        32'h0,        5'd0, 32'h0,        1'b0, 1'b0, 1'b0},
      '{OP_ADD, 32'h1,        32'h10,       5'd0, 32'h11,       1'b1, 1'b1, 1'b0},
      '{OP_SUB, 32'h0,        32'h0,        5'd0, 32'h0,        1'b0, 1'b0, 1'b0},
      '{OP_SUB, 32'h10,       32'h1,        5'd0, 32'hF,        1'b1, 1'b0, 1'b0},
      '{OP_ADD, 32'h80000000, 32'h80000000, 5'd0, 32'h0,        1'b0, 1'b0, 1'b1},
      '{OP_ADD, 32'h40000000, 32'h40000000, 5'd0, 32'h80000000, 1'b0, 1'b0, 1'b1},
      '{OP_SUB, 32'h80000000, 32'h80000000, 5'd0, 32'h0,        1'b0, 1'b0, 1'b0},
      '{OP_SUB, 32'h80000000, 32'h0F000000, 5'd0, 32'h71000000, 1'b1, 1'b1, 1'b1},
      '{OP_SUB, 32'h0FFFFFFF, 32'hFFFFFFFF, 5'd0, 32'h10000000, 1'b1, 1'b0, 1'b0},
      '{OP_SUB, 32'h80000001, 32'h7FFFFFFF, 5'd0, 32'h2,        1'b1, 1'b1, 1'b1},
      '{OP_SRA, 32'h80000000, 32'h0,        5'd4, 32'hF8000000, 1'b1, 1'b1, 1'b0},
      '{OP_SRA, 32'h0,        32'h0,        5'd0, 32'h0,        1'b0, 1'b0, 1'b0},
      '{OP_SRA, 32'h7000000F, 32'h0,        5'd31, 32'h0,       1'b1, 1'b0, 1'b0},
      '{OP_SLL, 32'hA5A5A5A5, 32'h0,        5'd0, 32'hA5A5A5A5, 1'b1, 1'b1, 1'b0},
      '{OP_AND, 32'h40000000, 32'h40000000, 5'd0, 32'h40000000, 1'b0, 1'b0, 1'b0},
      '{5'b11111, 32'h5,      32'h3,        5'd7, 32'h0,        1'b1, 1'b0, 1'b0},
      '{5'b00110, 32'h80000000, 32'h80000000, 5'd0, 32'h0,      1'b0, 1'b0, 1'b0}
    };

    bus.ctrl_ALUopcode = OP_ADD;
    bus.data_operandA  = 32'h12345678;
    bus.data_operandB  = 32'h11111111;
    bus.ctrl_shiftamt  = 5'd0;

    // Reset for two cycles with live operands, then check everything is cleared.
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    cmp("reset_result",     -1, bus.data_result,         32'h0);
    cmp("reset_isNotEqual", -1, {31'b0, bus.isNotEqual}, 32'h0);
    cmp("reset_isLessThan", -1, {31'b0, bus.isLessThan}, 32'h0);
    cmp("reset_overflow",   -1, {31'b0, bus.overflow},   32'h0);

    foreach (vecs[i]) begin
      v = vecs[i];
      apply(1'b0, v.op, v.a, v.b, v.amt, v.res, v.neq, v.lt, v.ovf);
    end

    // Doubling series: carry walks up one bit per step; only bit 30 overflows.
    for (int i = 0; i <= 30; i++) begin
      va = 32'h1 << i;
      apply(1'b0, OP_ADD, va, va, 5'd0, 32'h1 << (i + 1), 1'b0, 1'b0, (i == 30));
    end

    pats[0] = 32'h0;
    pats[1] = 32'hFFFFFFFF;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        va = pats[i];
        vb = pats[j];
        apply(1'b0, OP_OR,  va, vb, 5'd0, va | vb, (i != j), (i == 1 && j == 0), 1'b0);
        apply(1'b0, OP_AND, va, vb, 5'd0, va & vb, (i != j), (i == 1 && j == 0), 1'b0);
      end
    end

    amts = '{5'd1, 5'd2, 5'd4, 5'd8, 5'd16, 5'd3, 5'd6, 5'd12, 5'd24};
    for (int i = 0; i < 9; i++) begin
      apply(1'b0, OP_SLL, 32'h1, 32'h0, amts[i], 32'h1 << amts[i], 1'b1, 1'b0, 1'b0);
    end

    // Reset mid-stream wins over an overflowing op, then the stream resumes.
    apply(1'b0, OP_ADD, 32'h5,        32'h6,        5'd0, 32'hB,        1'b1, 1'b1, 1'b0);
    apply(1'b1, OP_ADD, 32'h7FFFFFFF, 32'h1,        5'd0, 32'h0,        1'b0, 1'b0, 1'b0);
    apply(1'b0, OP_SUB, 32'h80000000, 32'h1,        5'd0, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b1);
    apply(1'b0, OP_SRA, 32'h80000000, 32'h0,        5'd31, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0);

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_leftover got=%0d want=0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
